// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one SRAM-like port between fetch and data sides
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [AW-1:0]     inst_addr,
    output logic [DW-1:0]     inst_rdata,
    output logic              inst_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [DW/8-1:0]   data_wen,
    input  logic [AW-1:0]     data_addr,
    input  logic [DW-1:0]     data_wdata,
    output logic [DW-1:0]     data_rdata,
    output logic              data_ok,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [DW/8-1:0]   mem_wen,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DW-1:0]     mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]      state;
    logic            owner;
    logic            last_grant;
    logic            lat_wr;
    logic [DW/8-1:0] lat_wen;
    logic [AW-1:0]   lat_addr;
    logic [DW-1:0]   lat_wdata;

    logic grant_any;
    logic grant_data;
    logic complete;

    // On contention the side that was not served last wins; last_grant resets to inst so data wins first.
    always_comb begin
        grant_any  = inst_req | data_req;
        grant_data = data_req & (~inst_req | ~last_grant);
        complete   = mem_data_ok & (((state == ADDR) & mem_addr_ok) | (state == DATA));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            lat_wr     <= 1'b0;
            lat_wen    <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner      <= grant_data;
                        last_grant <= grant_data;
                        lat_wr     <= grant_data & data_wr;
                        lat_wen    <= grant_data ? data_wen : '0;
                        lat_addr   <= grant_data ? data_addr : inst_addr;
                        lat_wdata  <= grant_data ? data_wdata : '0;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (mem_addr_ok) begin
                        state <= mem_data_ok ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (mem_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory side sees only latched payload, so requesters may change inputs mid-transaction.
    always_comb begin
        mem_req    = (state == ADDR);
        mem_wr     = lat_wr;
        mem_wen    = lat_wen;
        mem_addr   = lat_addr;
        mem_wdata  = lat_wdata;
        inst_ok    = complete & ~owner;
        data_ok    = complete & owner;
        inst_rdata = inst_ok ? mem_rdata : '0;
        data_rdata = data_ok ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        inst_ok;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_ok;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
        .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ok(data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_data;
        bit          wr;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          chk_rd;
        int          req_first;
        int          req_last;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    int          addr_stall = 0;
    bit          fast = 1'b0;
    bit          manual = 1'b0;
    logic        man_addr_ok = 1'b0;
    logic        man_data_ok = 1'b0;
    logic [31:0] man_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit is_data, input bit wr, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        input bit chk_rd, input int rf, input int rl, input int dc);
        exp_t e;
        e.is_data = is_data; e.wr = wr; e.wen = wen; e.addr = addr; e.wdata = wdata;
        e.rdata = rdata; e.chk_rd = chk_rd; e.req_first = rf; e.req_last = rl; e.done_cyc = dc;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'hBFC00000: mem_model = 32'h24010001;
            32'h80000004: mem_model = 32'h12345678;
            default:      mem_model = a ^ 32'h5A5A5A5A;
        endcase
    endfunction

    // Memory responder: drives the memory-side handshakes 2 time units after each rising edge.
    initial begin
        int          wait_cnt;
        bit          in_data;
        logic [31:0] rd_val;
        wait_cnt = 0; in_data = 1'b0; rd_val = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (manual) begin
                mem_addr_ok = man_addr_ok; mem_data_ok = man_data_ok; mem_rdata = man_rdata;
                in_data = 1'b0; wait_cnt = 0;
            end else begin
                mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
                if (!rst) begin
                    in_data = 1'b0; wait_cnt = 0;
                end else if (in_data) begin
                    mem_data_ok = 1'b1; mem_rdata = rd_val; in_data = 1'b0;
                end else if (mem_req) begin
                    if (wait_cnt < addr_stall) begin
                        wait_cnt++;
                    end else begin
                        wait_cnt = 0;
                        mem_addr_ok = 1'b1;
                        rd_val = mem_model(mem_addr);
                        if (fast) begin
                            mem_data_ok = 1'b1; mem_rdata = rd_val;
                        end else begin
                            in_data = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Monitor: checks the memory-side payload and completions against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mem_req) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL stray_req: mem_req=1 with nothing expected at cycle %0d", cyc);
                    end else begin
                        e = sb[0];
                        chk("mem_addr", mem_addr, e.addr);
                        chk("mem_wr", 32'(mem_wr), 32'(e.wr));
                        chk("mem_wen", 32'(mem_wen), 32'(e.wen));
                        chk("mem_wdata", mem_wdata, e.wdata);
                        if (e.req_first >= 0)
                            chk("req_window", 32'(cyc >= e.req_first && cyc <= e.req_last), 32'd1);
                    end
                end
                if (inst_ok || data_ok) begin
                    chk("ok_exclusive", 32'(inst_ok & data_ok), 32'd0);
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL stray_ok: inst_ok=%0d data_ok=%0d with nothing expected at cycle %0d",
                                 inst_ok, data_ok, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("ok_owner", 32'(data_ok), 32'(e.is_data));
                        if (e.chk_rd) chk("rdata", e.is_data ? data_rdata : inst_rdata, e.rdata);
                        if (e.done_cyc >= 0) chk("done_cycle", cyc, e.done_cyc);
                    end
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
        chk({tag, "_mem_wen"}, 32'(mem_wen), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_inst_ok"}, 32'(inst_ok), 32'd0);
        chk({tag, "_data_ok"}, 32'(data_ok), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; inst_req = 1'b0; data_req = 1'b0;
        sb.delete();
        #1 check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_ok(input bit is_data);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(is_data ? data_ok : inst_ok) && t < 100);
        if (t >= 100) begin
            checks++; errors++;
            $display("FAIL timeout: no %s ok within 100 cycles", is_data ? "data" : "inst");
        end
    endtask

    task automatic inst_seq(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            inst_addr = base + 32'(4 * i);
            inst_req  = 1'b1;
            wait_ok(1'b0);
            @(posedge clk); #1;
        end
        inst_req = 1'b0;
    endtask

    task automatic data_seq(input int n, input bit wr, input logic [3:0] wen,
                            input logic [31:0] base, input logic [31:0] wdata);
        for (int i = 0; i < n; i++) begin
            data_wr = wr; data_wen = wen; data_wdata = wdata;
            data_addr = base + 32'(4 * i);
            data_req  = 1'b1;
            wait_ok(1'b1);
            @(posedge clk); #1;
        end
        data_req = 1'b0;
    endtask

    initial begin
        int k;

        // Single fetch, typical latency.
        do_reset();
        @(posedge clk); #1; k = cyc;
        push(0, 0, 4'h0, 32'hBFC00000, 32'h0, 32'h24010001, 1, k + 1, k + 1, k + 2);
        inst_seq(1, 32'hBFC00000);

        // Simultaneous requests after reset: data store first, then fetch.
        do_reset();
        @(posedge clk); #1; k = cyc;
        push(1, 1, 4'hF, 32'h80000010, 32'hDEADBEEF, 32'h0, 0, k + 1, k + 1, k + 2);
        push(0, 0, 4'h0, 32'hBFC00010, 32'h0, 32'hE59A5A4A, 1, k + 4, k + 4, k + 5);
        fork
            data_seq(1, 1'b1, 4'hF, 32'h80000010, 32'hDEADBEEF);
            inst_seq(1, 32'hBFC00010);
        join

        // Both held continuously: grants alternate.
        do_reset();
        @(posedge clk); #1; k = cyc;
        push(1, 0, 4'h0, 32'h80000100, 32'h0, 32'hDA5A5B5A, 1, k + 1,  k + 1,  k + 2);
        push(0, 0, 4'h0, 32'hBFC00004, 32'h0, 32'hE59A5A5E, 1, k + 4,  k + 4,  k + 5);
        push(1, 0, 4'h0, 32'h80000104, 32'h0, 32'hDA5A5B5E, 1, k + 7,  k + 7,  k + 8);
        push(0, 0, 4'h0, 32'hBFC00008, 32'h0, 32'hE59A5A52, 1, k + 10, k + 10, k + 11);
        fork
            data_seq(2, 1'b0, 4'h0, 32'h80000100, 32'h0);
            inst_seq(2, 32'hBFC00004);
        join

        // Address phase stalled 5 cycles while the requester changes its address.
        addr_stall = 5;
        @(posedge clk); #1; k = cyc;
        push(0, 0, 4'h0, 32'hBFC00040, 32'h0, 32'hE59A5A1A, 1, k + 1, k + 6, k + 7);
        inst_addr = 32'hBFC00040; inst_req = 1'b1;
        repeat (3) @(posedge clk);
        #1 inst_addr = 32'h00001234;
        wait_ok(1'b0);
        @(posedge clk); #1 inst_req = 1'b0;
        addr_stall = 0;

        // addr_ok and data_ok together in the first address cycle.
        fast = 1'b1;
        @(posedge clk); #1; k = cyc;
        push(1, 0, 4'h0, 32'h80000004, 32'h0, 32'h12345678, 1, k + 1, k + 1, k + 1);
        data_seq(1, 1'b0, 4'h0, 32'h80000004, 32'h0);
        @(negedge clk);
        chk("idle_after_fast_req", 32'(mem_req), 32'd0);
        chk("idle_after_fast_ok", 32'(data_ok), 32'd0);
        fast = 1'b0;

        // Reset while in DATA, then a stray data_ok after release.
        manual = 1'b1;
        @(posedge clk); #1; k = cyc;
        push(0, 0, 4'h0, 32'hBFC00020, 32'h0, 32'h0, 0, k + 1, k + 1, -1);
        inst_addr = 32'hBFC00020; inst_req = 1'b1;
        @(posedge clk); #1 man_addr_ok = 1'b1;
        @(posedge clk); #1 man_addr_ok = 1'b0;
        rst = 1'b0; inst_req = 1'b0;
        sb.delete();
        #1 check_outputs_zero("mid_reset");
        @(posedge clk); #1;
        rst = 1'b1; man_data_ok = 1'b1; man_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("stray_inst_ok", 32'(inst_ok), 32'd0);
        chk("stray_data_ok", 32'(data_ok), 32'd0);
        chk("stray_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1 man_data_ok = 1'b0;
        @(posedge clk); #1 manual = 1'b0;

        repeat (3) @(posedge clk);
        #1 chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
